// File: rtl/rx_align_pkg.sv
// Shared types and widths for the deserializer word aligner.
// The rotate helper describes what a bit-slipped training word looks like.
package rx_align_pkg;

  localparam int WORD_W = 8;
  localparam int SLIP_W = 3;
  localparam int TAP_W  = 7;

  localparam logic [WORD_W-1:0] DEF_TRAIN_PATTERN = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
    ST_STEP   = 3'd4,
    ST_LOCKED = 3'd5,
    ST_FAIL   = 3'd6
  } align_state_t;

  // Left-rotate a word by n bit positions (n = 0..7).
  function automatic logic [WORD_W-1:0] pattern_rotate(input logic [WORD_W-1:0] w,
                                                       input logic [2:0] n);
    logic [3:0] s;
    s = {1'b0, n};
    return (w << s) | (w >> (4'd8 - s));
  endfunction

endpackage

// File: rtl/rx_word_align_if.sv
// Signal bundle between the aligner and its deserializer / IODELAY / downstream logic.
interface rx_word_align_if;
  import rx_align_pkg::*;

  logic              start;
  logic [WORD_W-1:0] q_in;
  logic              calib;
  logic              dly_sdtap;
  logic              dly_value;
  logic              dly_setn;
  logic [SLIP_W-1:0] slip_cnt;
  logic [TAP_W-1:0]  tap_cnt;
  logic              locked;
  logic              fail;
  logic [WORD_W-1:0] data_out;
  logic              data_valid;

  modport master (
    output start, q_in,
    input  calib, dly_sdtap, dly_value, dly_setn, slip_cnt, tap_cnt,
           locked, fail, data_out, data_valid
  );

  modport slave (
    input  start, q_in,
    output calib, dly_sdtap, dly_value, dly_setn, slip_cnt, tap_cnt,
           locked, fail, data_out, data_valid
  );

endinterface

// File: rtl/rx_word_align.sv
// Training controller: bit-slips the IDES8 and steps the IODELAY until the
// training word is seen MATCH_COUNT times in a row, then forwards aligned data.
module rx_word_align
  import rx_align_pkg::*;
#(
  parameter logic [WORD_W-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter int                MATCH_COUNT   = 16,
  parameter int                SLIP_WAIT     = 4,
  parameter int                DLY_STEPS     = 32
) (
  input  logic             pclk,
  input  logic             reset,
  rx_word_align_if.slave   bus
);

  localparam logic [7:0]       MATCH_LAST = 8'(MATCH_COUNT - 1);
  localparam logic [3:0]       WAIT_LOAD  = 4'(SLIP_WAIT);
  localparam logic [TAP_W-1:0] TAP_MAX    = TAP_W'(DLY_STEPS);

  align_state_t      r_state, w_state_nxt;
  logic [7:0]        r_match, w_match_nxt;
  logic [3:0]        r_wait,  w_wait_nxt;
  logic [SLIP_W-1:0] r_slip,  w_slip_nxt;
  logic [TAP_W-1:0]  r_tap,   w_tap_nxt;
  logic              r_calib, r_dly_value, r_locked, r_fail, r_data_valid;
  logic [WORD_W-1:0] r_data_out;

  // Next-state and counter update; start wins over every state.
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    w_wait_nxt  = r_wait;
    w_slip_nxt  = r_slip;
    w_tap_nxt   = r_tap;
    if (bus.start) begin
      w_state_nxt = ST_WAIT;
      w_match_nxt = 8'd0;
      w_wait_nxt  = WAIT_LOAD;
      w_slip_nxt  = 3'd0;
      w_tap_nxt   = 7'd0;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_WAIT: begin
          if (r_wait == 4'd0) begin
            w_state_nxt = ST_CHECK;
          end else begin
            w_wait_nxt = r_wait - 4'd1;
          end
        end
        ST_CHECK: begin
          if (bus.q_in == TRAIN_PATTERN) begin
            w_match_nxt = r_match + 8'd1;
            if (r_match == MATCH_LAST) begin
              w_state_nxt = ST_LOCKED;
            end else begin
              w_state_nxt = ST_CHECK;
            end
          end else begin
            w_match_nxt = 8'd0;
            // slip_cnt only wraps through a tap step; taps saturate into FAIL
            if (r_slip != 3'd7) begin
              w_state_nxt = ST_SLIP;
              w_slip_nxt  = r_slip + 3'd1;
            end else if (r_tap < TAP_MAX) begin
              w_state_nxt = ST_STEP;
              w_tap_nxt   = r_tap + 7'd1;
              w_slip_nxt  = 3'd0;
            end else begin
              w_state_nxt = ST_FAIL;
            end
          end
        end
        ST_SLIP, ST_STEP: begin
          w_state_nxt = ST_WAIT;
          w_wait_nxt  = WAIT_LOAD;
        end
        ST_LOCKED: w_state_nxt = ST_LOCKED;
        ST_FAIL:   w_state_nxt = ST_FAIL;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered outputs (outputs decoded from the next state).
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_match      <= 8'd0;
      r_wait       <= 4'd0;
      r_slip       <= 3'd0;
      r_tap        <= 7'd0;
      r_calib      <= 1'b0;
      r_dly_value  <= 1'b0;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
      r_data_valid <= 1'b0;
      r_data_out   <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_match      <= w_match_nxt;
      r_wait       <= w_wait_nxt;
      r_slip       <= w_slip_nxt;
      r_tap        <= w_tap_nxt;
      r_calib      <= (w_state_nxt == ST_SLIP);
      r_dly_value  <= (w_state_nxt == ST_STEP);
      r_locked     <= (w_state_nxt == ST_LOCKED);
      r_fail       <= (w_state_nxt == ST_FAIL);
      r_data_valid <= (w_state_nxt == ST_LOCKED);
      r_data_out   <= bus.q_in;
    end
  end

  assign bus.calib      = r_calib;
  assign bus.dly_value  = r_dly_value;
  assign bus.dly_sdtap  = 1'b0;
  assign bus.dly_setn   = 1'b0;
  assign bus.slip_cnt   = r_slip;
  assign bus.tap_cnt    = r_tap;
  assign bus.locked     = r_locked;
  assign bus.fail       = r_fail;
  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;

endmodule

// File: doc/rx_word_align.md
Name: rx_word_align

Overview:
- Training controller and word aligner directly downstream of the 1:8 IODELAY/IDES8 deserializer.
- Consumes the 8-bit parallel word on pclk and hunts for a fixed training pattern by pulsing the deserializer's CALIB (bit-slip) input.
- When all 8 slips are exhausted without a match, it steps the IODELAY by one tap and hunts again.
- On lock it forwards aligned words and flags valid; it flags fail if all taps are exhausted.

Parameters:
- TRAIN_PATTERN, 8'hA5, training word; all 8 rotations are distinct.
- MATCH_COUNT, 16, consecutive matching words required to declare lock (2..255).
- SLIP_WAIT, 4, pclk cycles ignored after each CALIB or VALUE pulse before comparing (1..15).
- DLY_STEPS, 32, maximum IODELAY tap increments before fail (1..127).

Ports:
- pclk  in  1  parallel clock, same clock as the deserializer PCLK.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to (re)start training.
- q_in  in  8  deserialized word from the IDES8 Q[7:0].
- calib  out  1  bit-slip pulse to IDES8 CALIB.
- dly_sdtap  out  1  IODELAY SDTAP; tied 0 (dynamic VALUE stepping only).
- dly_value  out  1  IODELAY VALUE step pulse.
- dly_setn  out  1  IODELAY direction; constant 0 (increase delay).
- slip_cnt  out  3  slips applied at the current tap.
- tap_cnt  out  7  taps stepped since training started.
- locked  out  1  alignment achieved.
- fail  out  1  training exhausted without lock.
- data_out  out  8  aligned word (registered q_in).
- data_valid  out  1  high while locked.

Behaviour:
- Clocking and reset:
  - Single clock pclk.
  - Reset is synchronous and active-high; it overrides every other input.
  - Reset values: all outputs 0; state IDLE; match, wait, slip and tap counters 0.
- States: IDLE, WAIT, CHECK, SLIP, STEP, LOCKED, FAIL.
- IDLE:
  - Waits for start.
  - On start: clear slip_cnt, tap_cnt and the match counter, load the wait counter with SLIP_WAIT, go to WAIT.
- WAIT:
  - Decrements the wait counter each cycle and ignores q_in.
  - When the counter reaches 0, go to CHECK on the next cycle.
- CHECK, once per cycle:
  - If q_in == TRAIN_PATTERN, increment the match counter. When it reaches MATCH_COUNT, go to LOCKED.
  - On a mismatch, clear the match counter. Then:
    - slip_cnt < 7: go to SLIP.
    - slip_cnt == 7 and tap_cnt < DLY_STEPS: go to STEP.
    - otherwise: go to FAIL.
- SLIP:
  - calib = 1 for exactly one cycle and slip_cnt increments.
  - Reload the wait counter with SLIP_WAIT and go to WAIT.
- STEP:
  - dly_value = 1 for exactly one cycle, tap_cnt increments, slip_cnt clears to 0.
  - Reload the wait counter with SLIP_WAIT and go to WAIT.
- Pulse timing: calib and dly_value are registered; never both high; never high on consecutive cycles.
- LOCKED:
  - locked = 1 and data_valid = 1.
  - data_out = q_in delayed by 1 cycle; data_out is also updated in other states, but data_valid = 0 there.
  - No automatic lock-loss detection.
- FAIL: fail = 1, held until start or reset.
- start in any state other than IDLE:
  - Restarts training as from IDLE.
  - Clears locked, fail and data_valid on the next cycle.
  - Counters clear; the IODELAY is not rewound (the tap count is relative).
- Boundaries:
  - slip_cnt wraps 7→0 only via STEP.
  - tap_cnt saturates at DLY_STEPS; it never wraps.
  - A match arriving on the same cycle the wait counter expires is not counted; comparison starts in CHECK.
- Latency:
  - Minimum start-to-locked is 1 + SLIP_WAIT + MATCH_COUNT cycles when already aligned: 21 cycles with defaults.
- Output constants: dly_sdtap and dly_setn are constant 0.

Decomposition:
- Shared package rx_align_pkg:
  - State enum type.
  - Widths: WORD_W=8, SLIP_W=3, TAP_W=7.
  - Default TRAIN_PATTERN constant.
- No sub-module needed.
  - Optional: a pattern_rotate helper function in the package, used only by the bench model.

Test Plan:
- Aligned data: reset, then start with q_in = 8'hA5 constant.
  - locked = 1 exactly 21 cycles after start.
  - slip_cnt = 0, tap_cnt = 0, no calib pulse.
- Rotation 3: bench model rotates the pattern by one bit per calib pulse, starting at offset 3.
  - Exactly 5 calib pulses (a slip from offset 7 wraps to offset 0), each separated by ≥ SLIP_WAIT+1 cycles.
  - locked with slip_cnt = 5, data_out = 8'hA5.
- Delay needed: model matches only at tap 2 with offset 0.
  - Two full 8-position passes; dly_value pulses twice; slip_cnt resets to 0 after each.
  - Lock with tap_cnt = 2, slip_cnt = 0.
- Never matches: q_in = 8'h00.
  - fail = 1 after 32 dly_value pulses and 33×7 calib pulses (7 slips at each of 33 tap settings).
  - locked = 0, tap_cnt = 32.
- Restart and reset:
  - Assert start mid-CHECK: counters clear and WAIT is re-entered the next cycle.
  - Assert reset while calib is pulsing: all outputs read 0 the following cycle.
- Intermittent match: 15 matches, 1 mismatch, then matches.
  - Exactly one calib pulse.
  - Lock is not declared until a fresh 16 consecutive matches.
